// File: rtl/dmem_mmio_responder.sv
// Data memory with memory-mapped cycle counter, countdown timer and TX byte FIFO.
// The TX FIFO is built only when DMEM_TXFIFO_EN is defined.
module dmem_mmio_responder #(
   parameter int RAM_WORDS  = 4096,
   parameter int FIFO_DEPTH = 8,
   parameter int TICK_DIV   = 100000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address_dmem,
   input  logic [31:0] data,
   input  logic        wren,
   output logic [31:0] q_dmem,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int RW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [31:0] A_CYCLE  = 32'h0000_1000;
   localparam logic [31:0] A_TIMER  = 32'h0000_1001;
   localparam logic [31:0] A_TSTAT  = 32'h0000_1002;
   localparam logic [31:0] A_TXDATA = 32'h0000_1003;
   localparam logic [31:0] A_TXSTAT = 32'h0000_1004;

   logic [31:0] ram [RAM_WORDS];
   logic [31:0] cycle;
   logic [26:0] count;
   logic [PW-1:0] presc;
   logic running;
   logic done;
   logic [31:0] txstat;
   logic [31:0] rdata;

   logic ram_hit;
   logic wr_ram;
   logic wr_timer;
   logic wr_tstat;

   assign ram_hit  = address_dmem < 32'(RAM_WORDS);
   assign wr_ram   = wren && ram_hit;
   assign wr_timer = wren && (address_dmem == A_TIMER);
   assign wr_tstat = wren && (address_dmem == A_TSTAT);

   always_ff @(posedge clock) begin
      if (wr_ram)
         ram[address_dmem[RW-1:0]] <= data;
   end

   always_comb begin
      rdata = '0;
      if (ram_hit) begin
         rdata = ram[address_dmem[RW-1:0]];
      end else begin
         case (address_dmem)
            A_CYCLE:  rdata = cycle;
            A_TIMER:  rdata = {5'b0, count};
            A_TSTAT:  rdata = {30'b0, running, done};
            A_TXSTAT: rdata = txstat;
            default:  rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_dmem <= '0;
         cycle  <= '0;
      end else begin
         q_dmem <= rdata;
         cycle  <= cycle + 32'd1;
      end
   end

   // A zero load expires at once rather than running.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count   <= '0;
         presc   <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else if (wr_timer) begin
         count   <= data[26:0];
         presc   <= '0;
         running <= (data[26:0] != 27'd0);
         done    <= (data[26:0] == 27'd0);
      end else begin
         if (wr_tstat)
            done <= 1'b0;
         if (running) begin
            if (presc == PW'(TICK_DIV - 1)) begin
               presc <= '0;
               count <= count - 27'd1;
               if (count == 27'd1) begin
                  running <= 1'b0;
                  done    <= 1'b1;
               end
            end else begin
               presc <= presc + PW'(1);
            end
         end
      end
   end

`ifdef DMEM_TXFIFO_EN
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [7:0] fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] cnt;
   logic ovf;
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic do_push;
   logic wr_txstat;

   assign full      = (cnt == CW'(FIFO_DEPTH));
   assign empty     = (cnt == '0);
   assign push      = wren && (address_dmem == A_TXDATA);
   assign wr_txstat = wren && (address_dmem == A_TXSTAT);
   assign pop       = !empty && tx_ready;
   // A pop in the same edge frees the slot a full push needs.
   assign do_push   = push && (!full || pop);

   always_ff @(posedge clock) begin
      if (do_push)
         fifo_mem[wptr] <= data[7:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
      end else begin
         if (do_push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         case ({do_push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
         if (wr_txstat)
            ovf <= 1'b0;
         else if (push && !do_push)
            ovf <= 1'b1;
      end
   end

   assign tx_valid = !empty;
   assign tx_data  = empty ? 8'h00 : fifo_mem[rptr];

   always_comb begin
      txstat = '0;
      txstat[8 +: CW] = cnt;
      txstat[2:0] = {ovf, empty, full};
   end
`else
   logic unused_ok;

   assign unused_ok = tx_ready;
   assign tx_valid  = 1'b0;
   assign tx_data   = 8'h00;
   assign txstat    = 32'h0000_0002;
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder; FIFO or no-FIFO
// scenarios follow DMEM_TXFIFO_EN.
module tb_dmem_mmio_responder;

   localparam logic [31:0] A_CYCLE  = 32'h1000;
   localparam logic [31:0] A_TIMER  = 32'h1001;
   localparam logic [31:0] A_TSTAT  = 32'h1002;
   localparam logic [31:0] A_TXDATA = 32'h1003;
   localparam logic [31:0] A_TXSTAT = 32'h1004;

   logic        clock;
   logic        reset;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int errors = 0;
   int checks = 0;

   dmem_mmio_responder #(
      .RAM_WORDS(4096),
      .FIFO_DEPTH(8),
      .TICK_DIV(4)
   ) dut (
      .clock(clock),
      .reset(reset),
      .address_dmem(address_dmem),
      .data(data),
      .wren(wren),
      .q_dmem(q_dmem),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h",
                  tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write_word(input logic [31:0] a,
                             input logic [31:0] d);
      address_dmem = a;
      data = d;
      wren = 1'b1;
      step();
      wren = 1'b0;
      data = '0;
   endtask

   initial begin
      reset = 1'b0;
      wren = 1'b0;
      data = '0;
      address_dmem = A_CYCLE;
      tx_ready = 1'b0;
      #1;
      chk("rst_q", q_dmem, 32'h0);
      chk("rst_valid", {31'b0, tx_valid}, 32'h0);
      #21 reset = 1'b1;

      step();
      chk("cycle0", q_dmem, 32'd0);
      step();
      chk("cycle1", q_dmem, 32'd1);
      step();
      chk("cycle2", q_dmem, 32'd2);

      write_word(32'h5, 32'h1111_1111);
      write_word(32'h5, 32'hDEAD_BEEF);
      chk("ram_rbw", q_dmem, 32'h1111_1111);
      address_dmem = 32'h5;
      step();
      chk("ram_rd", q_dmem, 32'hDEAD_BEEF);

      write_word(32'h2000, 32'h1234_5678);
      address_dmem = 32'h2000;
      step();
      chk("unmapped", q_dmem, 32'h0);

      write_word(A_TIMER, 32'd3);
      address_dmem = A_TSTAT;
      repeat (12) step();
      chk("tmr_run11", q_dmem, 32'h2);
      step();
      chk("tmr_done12", q_dmem, 32'h1);
      address_dmem = A_TIMER;
      step();
      chk("tmr_cnt0", q_dmem, 32'h0);
      write_word(A_TSTAT, 32'h1);
      address_dmem = A_TSTAT;
      step();
      chk("tstat_clr", q_dmem, 32'h0);

      write_word(A_TIMER, 32'd0);
      address_dmem = A_TSTAT;
      step();
      chk("tmr_zero", q_dmem, 32'h1);

`ifdef DMEM_TXFIFO_EN
      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++)
         write_word(A_TXDATA, 32'h41 + i);
      address_dmem = A_TXSTAT;
      step();
      chk("fifo_full", q_dmem, 32'h805);
      chk("fifo_head", {24'b0, tx_data}, 32'h41);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("fifo_order", {24'b0, tx_data}, 32'h41 + i);
         step();
      end
      tx_ready = 1'b0;
      chk("fifo_drained", {31'b0, tx_valid}, 32'h0);
      step();
      chk("fifo_empty_ovf", q_dmem, 32'h006);
      write_word(A_TXSTAT, 32'h0);
      address_dmem = A_TXSTAT;
      step();
      chk("ovf_clr", q_dmem, 32'h002);

      for (int i = 0; i < 8; i++)
         write_word(A_TXDATA, 32'h60 + i);
      tx_ready = 1'b1;
      write_word(A_TXDATA, 32'h68);
      tx_ready = 1'b0;
      address_dmem = A_TXSTAT;
      step();
      chk("pushpop_full", q_dmem, 32'h801);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("pushpop_order", {24'b0, tx_data}, 32'h61 + i);
         step();
      end
      tx_ready = 1'b0;
      chk("pushpop_empty", {31'b0, tx_valid}, 32'h0);

      for (int i = 0; i < 3; i++)
         write_word(A_TXDATA, 32'h70 + i);
`else
      write_word(A_TXDATA, 32'h55);
      chk("cfg_valid", {31'b0, tx_valid}, 32'h0);
      address_dmem = A_TXSTAT;
      step();
      chk("cfg_txstat", q_dmem, 32'h2);
      chk("cfg_data", {24'b0, tx_data}, 32'h0);
`endif

      write_word(A_TIMER, 32'd100);
      address_dmem = A_TSTAT;
      step();
      chk("pre_rst_run", q_dmem, 32'h2);
      address_dmem = A_CYCLE;
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_q", q_dmem, 32'h0);
      chk("mid_rst_valid", {31'b0, tx_valid}, 32'h0);
      chk("mid_rst_data", {24'b0, tx_data}, 32'h0);
      #2 reset = 1'b1;
      step();
      chk("post_cycle0", q_dmem, 32'd0);
      step();
      chk("post_cycle1", q_dmem, 32'd1);
      address_dmem = A_TIMER;
      step();
      chk("post_timer", q_dmem, 32'h0);
      address_dmem = A_TSTAT;
      step();
      chk("post_tstat", q_dmem, 32'h0);
      address_dmem = 32'h5;
      step();
      chk("post_ram", q_dmem, 32'hDEAD_BEEF);
      address_dmem = A_TXSTAT;
      step();
      chk("post_txstat", q_dmem, 32'h2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_mmio_responder.md
DMEM_MMIO_RESPONDER -- requirements
Module: dmem_mmio_responder

Interface
REQ-001 Parameters SHALL be: RAM_WORDS, default 4096, RAM depth in words; FIFO_DEPTH, default 8, TX FIFO entries (power of 2); TICK_DIV, default 100000, clock cycles per timer tick.
REQ-002 Ports SHALL be, clock and reset first:
- clock  in  1  master clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- address_dmem  in  32  word address from the processor.
- data  in  32  write data from the processor.
- wren  in  1  write enable.
- q_dmem  out  32  read data to the processor.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  downstream accepts the head byte.

Function
REQ-003 Memory map, word addresses: 0x0000..RAM_WORDS-1 RAM; 0x1000 CYCLE (RO); 0x1001 TIMER (RW); 0x1002 TSTAT (RW); 0x1003 TXDATA (WO); 0x1004 TXSTAT (RW). Unmapped addresses SHALL read 0 and ignore writes.
REQ-004 Read latency SHALL be 1 cycle: q_dmem is registered from the address present at the rising edge.
REQ-005 A RAM write with wren=1 SHALL commit at the rising edge. A same-address read in that cycle SHALL return the old data (read-before-write).
REQ-006 CYCLE SHALL be a 32-bit free-running counter, +1 every cycle, wrapping 0xFFFFFFFF->0. Writes to CYCLE SHALL be ignored.
REQ-007 A write to TIMER SHALL:
- load the count from data[26:0];
- clear the prescaler and TSTAT.done;
- set running.
REQ-008 While running, the prescaler SHALL count 0..TICK_DIV-1. On wrap the count SHALL decrement. When the count reaches 0, running SHALL clear and TSTAT.done (bit0) SHALL set and stay set.
REQ-009 A TIMER write of 0 SHALL set done on the next edge without running.
REQ-010 A TIMER read SHALL return the remaining count; TSTAT bit1 SHALL read running.
REQ-011 Any write to TSTAT SHALL clear done. A TIMER reload in progress SHALL restart timing from the new value.
REQ-012 A write to TXDATA SHALL push data[7:0]. A push when full SHALL be dropped and SHALL set the sticky overflow bit, TXSTAT bit2.
REQ-013 A pop SHALL occur when tx_valid and tx_ready are both 1 at an edge. tx_data SHALL always show the head entry.
REQ-014 Push and pop in the same cycle SHALL both take effect, including when full; the count is then unchanged and no overflow occurs.
REQ-015 TXSTAT read SHALL return: bit0 full, bit1 empty, bit2 overflow, bits[11:8] count. A write to TXSTAT SHALL clear overflow.
REQ-016 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-017 Reset asserted low SHALL immediately force:
- q_dmem=0, CYCLE=0;
- timer count, prescaler, running and done to 0;
- FIFO empty, overflow=0, tx_valid=0, tx_data=0.
RAM contents SHALL be unaffected.
REQ-018 Reset mid-operation SHALL abandon a running timer and discard FIFO contents. The first count after release SHALL be CYCLE=1 at the first rising edge.

Configuration
REQ-019 Macro DMEM_TXFIFO_EN SHALL control the TX FIFO feature.
- Defined: the TX FIFO is built as in REQ-012..REQ-016.
- Undefined: no FIFO storage is built; TXDATA writes are ignored; tx_valid=0 and tx_data=0 constantly; TXSTAT reads 0x2.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- RAM: write 0xDEADBEEF to 0x0005, then read 0x0005 -> q_dmem=0xDEADBEEF one cycle later; read-before-write check on the same address returns the old value.
- Timer: TICK_DIV=4, write TIMER=3 -> done=1 exactly 12 cycles after the write edge, running=0; TSTAT write -> done=0.
- FIFO: tx_ready=0, push 0x41..0x49 (9 bytes) -> full=1, overflow=1, count=8; then tx_ready=1 -> bytes 0x41..0x48 out in order, empty=1.
- Simultaneous push and pop when full -> count stays 8, overflow stays 0, new byte appears last.
- Reset: assert reset low while the timer is running and the FIFO holds 3 bytes -> tx_valid=0, TIMER=0, CYCLE=0 immediately; RAM word 0x0005 still reads 0xDEADBEEF.
- Config: build without DMEM_TXFIFO_EN, write TXDATA=0x55 -> tx_valid stays 0, TXSTAT reads 0x2.
